// File: rtl/phase_seq_controller_if.sv
// rtl/phase_seq_controller_if.sv - IR/datapath handshake bundle for phase_seq_controller
//
// Purpose: groups the instruction-register fields, ALU flags, the RAM ready
// handshake and all datapath strobes into one bundle.
// Modports:
//   master - the sequence controller (consumes IR/flags/ram_rdy, drives strobes)
//   slave  - the IR/datapath/RAM side (drives IR/flags/ram_rdy, consumes strobes)
// Signals:
//   run, opcode[3:0], i_flag, addr[ADDR_W-1:0], of, sf, zf, cf, ram_rdy
//   phase[2:0], ir_en, a_en, b_en, pdr_en, pc_en, pc_load, alu_en, alu_oe,
//   ram_oe, rdr_en, port_en[NUM_PORTS-1:0], port_rd[NUM_PORTS-1:0],
//   ram_cs (active low), bus_err (sticky)
interface phase_seq_controller_if #(
  parameter int ADDR_W    = 7,
  parameter int NUM_PORTS = 1
);
  logic                 run;
  logic [3:0]           opcode;
  logic                 i_flag;
  logic [ADDR_W-1:0]    addr;
  logic                 of;
  logic                 sf;
  logic                 zf;
  logic                 cf;
  logic                 ram_rdy;

  logic [2:0]           phase;
  logic                 ir_en;
  logic                 a_en;
  logic                 b_en;
  logic                 pdr_en;
  logic                 pc_en;
  logic                 pc_load;
  logic                 alu_en;
  logic                 alu_oe;
  logic                 ram_oe;
  logic                 rdr_en;
  logic [NUM_PORTS-1:0] port_en;
  logic [NUM_PORTS-1:0] port_rd;
  logic                 ram_cs;
  logic                 bus_err;

  modport master (
    input  run, opcode, i_flag, addr, of, sf, zf, cf, ram_rdy,
    output phase, ir_en, a_en, b_en, pdr_en, pc_en, pc_load, alu_en, alu_oe,
           ram_oe, rdr_en, port_en, port_rd, ram_cs, bus_err
  );

  modport slave (
    output run, opcode, i_flag, addr, of, sf, zf, cf, ram_rdy,
    input  phase, ir_en, a_en, b_en, pdr_en, pc_en, pc_load, alu_en, alu_oe,
           ram_oe, rdr_en, port_en, port_rd, ram_cs, bus_err
  );
endinterface

// File: rtl/phase_seq_controller.sv
// rtl/phase_seq_controller.sv - FETCH/DECODE/EXECUTE/UPDATE sequencer for the RISCY core
//
// Purpose: generates the instruction phase sequence internally and decodes the
// IR fields into datapath strobes, with a RAM ready/wait handshake and timeout.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - phase_seq_controller_if.master (IR fields, flags, ram_rdy in;
//           phase, strobes, ram_cs, bus_err out)
// Optional feature: define SEQ_CTRL_HALT_EN to make opcode 4'b1111 a HALT that
// parks in HALTED until a registered rising edge of run.
module phase_seq_controller #(
  parameter int ADDR_W    = 7,
  parameter int IO_BASE   = 64,
  parameter int NUM_PORTS = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  phase_seq_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    UPDATE  = 3'd4,
    HALTED  = 3'd5
  } phase_t;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_B     = 4'd8;
  localparam logic [3:0] OP_BZ    = 4'd9;
  localparam logic [3:0] OP_BN    = 4'd10;
  localparam logic [3:0] OP_BV    = 4'd11;
  localparam logic [3:0] OP_BC    = 4'd12;

  phase_t               state, state_nxt;
  logic [7:0]           wait_cnt;
  logic                 bus_err_q;
  logic                 set_err;
  logic                 is_load, is_store, is_alu;
  logic                 ram_access;
  logic                 timed_out;
  logic                 hit_a, hit_b, hit_pdr;
  logic [NUM_PORTS-1:0] hit_port;
  logic                 halt_op;
  logic                 run_rise;

`ifdef SEQ_CTRL_HALT_EN
  // run is registered so HALTED only exits on a genuine 0->1 transition.
  logic run_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= bus.run;
  end
  assign halt_op  = (bus.opcode == 4'hF);
  assign run_rise = bus.run && !run_q;
`else
  assign halt_op  = 1'b0;
  assign run_rise = 1'b0;
`endif

  // I/O map decode: at most one hit because every target has a distinct address.
  always_comb begin
    hit_a   = (int'(bus.addr) == IO_BASE);
    hit_b   = (int'(bus.addr) == IO_BASE + 1);
    hit_pdr = (int'(bus.addr) == IO_BASE + 2);
    for (int k = 0; k < NUM_PORTS; k++) begin
      hit_port[k] = (int'(bus.addr) == IO_BASE + 3 + k);
    end
  end

  assign is_load  = (bus.opcode == OP_LOAD);
  assign is_store = (bus.opcode == OP_STORE);
  assign is_alu   = (bus.opcode >= 4'd2) && (bus.opcode <= 4'd7);

  // States that wait on ram_rdy and are subject to the timeout.
  assign ram_access = (state == FETCH) ||
                      ((state == EXECUTE) && ((is_load && !bus.i_flag) || is_store));
  assign timed_out  = ram_access && !bus.ram_rdy && (wait_cnt == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Every state change clears the counter, which covers entry into FETCH
      // and into a RAM-access EXECUTE.
      if (state_nxt != state)                wait_cnt <= 8'd0;
      else if (ram_access && !bus.ram_rdy)   wait_cnt <= wait_cnt + 8'd1;
      if (set_err) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    case (state)
      IDLE:    if (bus.run) state_nxt = FETCH;
      FETCH: begin
        if (bus.ram_rdy) state_nxt = DECODE;
        else if (timed_out) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
        end
      end
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: begin
        if (halt_op)                         state_nxt = HALTED;
        else if (!ram_access || bus.ram_rdy) state_nxt = UPDATE;
        else if (timed_out) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
        end
      end
      UPDATE:  state_nxt = bus.run ? FETCH : IDLE;
      HALTED:  if (run_rise) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ir_en   = 1'b0;
    bus.a_en    = 1'b0;
    bus.b_en    = 1'b0;
    bus.pdr_en  = 1'b0;
    bus.pc_en   = 1'b0;
    bus.pc_load = 1'b0;
    bus.alu_en  = 1'b0;
    bus.alu_oe  = 1'b0;
    bus.ram_oe  = 1'b0;
    bus.rdr_en  = 1'b0;
    bus.port_en = '0;
    bus.port_rd = '0;
    bus.ram_cs  = 1'b1;
    case (state)
      FETCH: begin
        bus.ram_cs = 1'b0;
        bus.ram_oe = 1'b1;
        bus.ir_en  = 1'b1;
      end
      EXECUTE: begin
        if (is_load) begin
          bus.a_en    = hit_a;
          bus.b_en    = hit_b;
          bus.pdr_en  = hit_pdr;
          bus.port_en = hit_port;
          if (!bus.i_flag) begin
            bus.ram_cs = 1'b0;
            bus.ram_oe = 1'b1;
            bus.rdr_en = 1'b1;
          end
        end else if (is_store) begin
          bus.ram_cs = 1'b0;
          // A store to a port address moves port input onto the bus instead of the ALU.
          if (|hit_port) bus.port_rd = hit_port;
          else           bus.alu_oe  = 1'b1;
        end else if (is_alu) begin
          bus.alu_en = 1'b1;
          bus.alu_oe = 1'b1;
        end
      end
      UPDATE: begin
        bus.pc_en   = 1'b1;
        bus.pc_load = (bus.opcode == OP_B) ||
                      ((bus.opcode == OP_BZ) && bus.zf) ||
                      ((bus.opcode == OP_BN) && bus.sf) ||
                      ((bus.opcode == OP_BV) && bus.of) ||
                      ((bus.opcode == OP_BC) && bus.cf);
      end
      default: ;
    endcase
  end

  assign bus.phase   = state;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_phase_seq_controller.sv
// tb/tb_phase_seq_controller.sv - directed self-checking bench for phase_seq_controller
module tb_phase_seq_controller;

  localparam logic [9:0] S_NONE   = 10'b0000000000;
  localparam logic [9:0] S_FETCH  = 10'b1000000010;
  localparam logic [9:0] S_ALU    = 10'b0000001100;
  localparam logic [9:0] S_ALUOE  = 10'b0000000100;
  localparam logic [9:0] S_UPD    = 10'b0000100000;
  localparam logic [9:0] S_LDB    = 10'b0010000011;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  phase_seq_controller_if #(.ADDR_W(7), .NUM_PORTS(4)) bus ();

  phase_seq_controller #(
    .ADDR_W(7), .IO_BASE(64), .NUM_PORTS(4), .TIMEOUT(15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ir,a,b,pdr,pc_en,pc_load,alu_en,alu_oe,ram_oe,rdr}
  function automatic logic [9:0] strobes();
    return {bus.ir_en, bus.a_en, bus.b_en, bus.pdr_en, bus.pc_en, bus.pc_load,
            bus.alu_en, bus.alu_oe, bus.ram_oe, bus.rdr_en};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.run     = 1'b0;
    bus.opcode  = 4'd0;
    bus.i_flag  = 1'b0;
    bus.addr    = 7'd0;
    bus.of      = 1'b0;
    bus.sf      = 1'b0;
    bus.zf      = 1'b0;
    bus.cf      = 1'b0;
    bus.ram_rdy = 1'b1;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus.phase !== 3'd0 || strobes() !== S_NONE || bus.ram_cs !== 1'b1 ||
        bus.bus_err !== 1'b0 || bus.port_en !== 4'd0 || bus.port_rd !== 4'd0) begin
      err_cnt++;
      $display("FAIL reset_state got phase=%0d strobes=%b cs=%b err=%b pe=%b pr=%b want 0 0000000000 1 0 0000 0000",
               bus.phase, strobes(), bus.ram_cs, bus.bus_err, bus.port_en, bus.port_rd);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_alu_sequence();
    logic [2:0] ph [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [9:0] st [5] = '{S_FETCH, S_NONE, S_ALU, S_UPD, S_FETCH};
    logic       cs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] ph2 [4] = '{3'd2, 3'd3, 3'd4, 3'd0};
    do_reset();
    bus.opcode = 4'd2;
    bus.run    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vec_cnt++;
      if (bus.phase !== ph[i] || strobes() !== st[i] || bus.ram_cs !== cs[i]) begin
        err_cnt++;
        $display("FAIL alu_seq[%0d] got phase=%0d strobes=%b cs=%b want %0d %b %b",
                 i, bus.phase, strobes(), bus.ram_cs, ph[i], st[i], cs[i]);
      end
    end
    // run drops during FETCH: instruction completes, then IDLE
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++;
      if (bus.phase !== ph2[i]) begin
        err_cnt++;
        $display("FAIL run_drop[%0d] got phase=%0d want %0d", i, bus.phase, ph2[i]);
      end
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    bus.opcode = 4'd0;
    bus.i_flag = 1'b0;
    bus.addr   = 7'd65;
    bus.run    = 1'b1;
    step();
    step();
    bus.ram_rdy = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) bus.ram_rdy = 1'b1;
      #1;
      vec_cnt++;
      if (bus.phase !== 3'd3 || strobes() !== S_LDB || bus.ram_cs !== 1'b0) begin
        err_cnt++;
        $display("FAIL load_wait[%0d] got phase=%0d strobes=%b cs=%b want 3 %b 0",
                 c, bus.phase, strobes(), bus.ram_cs, S_LDB);
      end
      if (c < 3) step();
    end
    bus.run = 1'b0;
    step();
    vec_cnt++;
    if (bus.phase !== 3'd4 || strobes() !== S_UPD) begin
      err_cnt++;
      $display("FAIL load_wait_update got phase=%0d strobes=%b want 4 %b", bus.phase, strobes(), S_UPD);
    end
  endtask

  task automatic test_load_imm();
    logic [6:0] ad [4] = '{7'd64, 7'd66, 7'd70, 7'd10};
    logic [9:0] st [4] = '{10'b0100000000, 10'b0001000000, S_NONE, S_NONE};
    logic [3:0] pe [4] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      bus.opcode = 4'd0;
      bus.i_flag = 1'b1;
      bus.addr   = ad[i];
      bus.run    = 1'b1;
      step();
      step();
      step();
      bus.run = 1'b0;
      #1;
      vec_cnt++;
      if (bus.phase !== 3'd3 || strobes() !== st[i] || bus.port_en !== pe[i] ||
          bus.ram_cs !== 1'b1 || bus.port_rd !== 4'd0) begin
        err_cnt++;
        $display("FAIL load_imm[%0d] got phase=%0d strobes=%b pe=%b cs=%b pr=%b want 3 %b %b 1 0000",
                 i, bus.phase, strobes(), bus.port_en, bus.ram_cs, bus.port_rd, st[i], pe[i]);
      end
      step();
      vec_cnt++;
      if (bus.phase !== 3'd4) begin
        err_cnt++;
        $display("FAIL load_imm_one_cycle[%0d] got phase=%0d want 4", i, bus.phase);
      end
    end
  endtask

  task automatic test_store_ports();
    do_reset();
    bus.opcode = 4'd1;
    bus.addr   = 7'd69;
    bus.run    = 1'b1;
    step();
    step();
    step();
    vec_cnt++;
    if (bus.phase !== 3'd3 || bus.port_rd !== 4'b0100 || bus.ram_cs !== 1'b0 ||
        strobes() !== S_NONE || bus.port_en !== 4'd0) begin
      err_cnt++;
      $display("FAIL store_port got phase=%0d pr=%b cs=%b strobes=%b pe=%b want 3 0100 0 0000000000 0000",
               bus.phase, bus.port_rd, bus.ram_cs, strobes(), bus.port_en);
    end
    step();
    bus.addr = 7'd10;
    step();
    step();
    step();
    bus.run = 1'b0;
    #1;
    vec_cnt++;
    if (bus.phase !== 3'd3 || bus.port_rd !== 4'd0 || bus.ram_cs !== 1'b0 || strobes() !== S_ALUOE) begin
      err_cnt++;
      $display("FAIL store_mem got phase=%0d pr=%b cs=%b strobes=%b want 3 0000 0 %b",
               bus.phase, bus.port_rd, bus.ram_cs, strobes(), S_ALUOE);
    end
  endtask

  task automatic test_branch();
`ifdef SEQ_CTRL_HALT_EN
    localparam int N = 7;
    logic [3:0] op [N] = '{4'd9, 4'd9, 4'd12, 4'd8, 4'd10, 4'd11, 4'd2};
    logic [3:0] fl [N] = '{4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b1011, 4'b1000, 4'b1111};
    logic       ld [N] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    localparam int N = 8;
    logic [3:0] op [N] = '{4'd9, 4'd9, 4'd12, 4'd8, 4'd10, 4'd11, 4'd2, 4'd15};
    logic [3:0] fl [N] = '{4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b1011, 4'b1000, 4'b1111, 4'b1111};
    logic       ld [N] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
    // fl = {of, sf, zf, cf}
    for (int i = 0; i < N; i++) begin
      do_reset();
      bus.opcode = op[i];
      {bus.of, bus.sf, bus.zf, bus.cf} = fl[i];
      bus.run = 1'b1;
      step();
      step();
      step();
      bus.run = 1'b0;
      step();
      vec_cnt++;
      if (bus.phase !== 3'd4 || bus.pc_en !== 1'b1 || bus.pc_load !== ld[i]) begin
        err_cnt++;
        $display("FAIL branch[%0d] op=%0d got phase=%0d pc_en=%b pc_load=%b want 4 1 %b",
                 i, op[i], bus.phase, bus.pc_en, bus.pc_load, ld[i]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.ram_rdy = 1'b0;
    bus.run     = 1'b1;
    step();
    for (int i = 1; i <= 15; i++) begin
      step();
      vec_cnt++;
      if (bus.phase !== 3'd1 || bus.bus_err !== 1'b0) begin
        err_cnt++;
        $display("FAIL timeout_wait[%0d] got phase=%0d err=%b want 1 0", i, bus.phase, bus.bus_err);
      end
    end
    step();
    bus.run = 1'b0;
    #1;
    vec_cnt++;
    if (bus.phase !== 3'd0 || bus.bus_err !== 1'b1 || bus.ram_cs !== 1'b1) begin
      err_cnt++;
      $display("FAIL timeout_hit got phase=%0d err=%b cs=%b want 0 1 1", bus.phase, bus.bus_err, bus.ram_cs);
    end
    step();
    step();
    bus.run = 1'b1;
    step();
    vec_cnt++;
    if (bus.phase !== 3'd1 || bus.bus_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL bus_err_sticky got phase=%0d err=%b want 1 1", bus.phase, bus.bus_err);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus.bus_err !== 1'b0 || bus.phase !== 3'd0) begin
      err_cnt++;
      $display("FAIL bus_err_reset got err=%b phase=%0d want 0 0", bus.bus_err, bus.phase);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.opcode = 4'd0;
    bus.i_flag = 1'b0;
    bus.addr   = 7'd64;
    bus.run    = 1'b1;
    step();
    step();
    bus.ram_rdy = 1'b0;
    step();
    vec_cnt++;
    if (bus.phase !== 3'd3 || bus.a_en !== 1'b1 || bus.ram_cs !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_pre got phase=%0d a_en=%b cs=%b want 3 1 0", bus.phase, bus.a_en, bus.ram_cs);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus.phase !== 3'd0 || strobes() !== S_NONE || bus.ram_cs !== 1'b1 || bus.port_en !== 4'd0) begin
      err_cnt++;
      $display("FAIL async_reset got phase=%0d strobes=%b cs=%b pe=%b want 0 0000000000 1 0000",
               bus.phase, strobes(), bus.ram_cs, bus.port_en);
    end
    rst_n = 1'b1;
  endtask

`ifdef SEQ_CTRL_HALT_EN
  task automatic test_halt();
    do_reset();
    bus.opcode = 4'd15;
    bus.run    = 1'b1;
    step();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++;
      if (bus.phase !== 3'd5 || strobes() !== S_NONE || bus.ram_cs !== 1'b1) begin
        err_cnt++;
        $display("FAIL halt_hold[%0d] got phase=%0d strobes=%b cs=%b want 5 0000000000 1",
                 i, bus.phase, strobes(), bus.ram_cs);
      end
    end
    bus.run = 1'b0;
    step();
    vec_cnt++;
    if (bus.phase !== 3'd5) begin
      err_cnt++;
      $display("FAIL halt_run_low got phase=%0d want 5", bus.phase);
    end
    bus.run = 1'b1;
    step();
    vec_cnt++;
    if (bus.phase !== 3'd1) begin
      err_cnt++;
      $display("FAIL halt_exit got phase=%0d want 1", bus.phase);
    end
  endtask
`endif

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    test_reset();
    test_alu_sequence();
    test_load_wait();
    test_load_imm();
    test_store_ports();
    test_branch();
    test_timeout();
    test_async_reset();
`ifdef SEQ_CTRL_HALT_EN
    test_halt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/phase_seq_controller.md
# phase_seq_controller

Parametrised sequence controller for the RISCY core. It generates the FETCH/DECODE/EXECUTE/UPDATE phase sequence internally, so there is no external phase input. It decodes the instruction register fields into datapath strobes and supports multiple I/O ports. RAM accesses use a ready/wait handshake with a timeout. It sits between the instruction register and the datapath (ALU A/B registers, port registers, PC, RAM).

## Interface
Parameters:
- ADDR_W, 7, width of instruction address field
- IO_BASE, 64, first I/O-mapped address (A reg); IO_BASE+1 = B reg, IO_BASE+2 = PDR, IO_BASE+3+k = port k
- NUM_PORTS, 1, number of I/O ports (1-4)
- TIMEOUT, 15, maximum RAM_RDY wait cycles before bus error (1-255)

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- RUN  in  1  level; permits leaving IDLE and continuing after UPDATE
- OPCODE  in  4  IR opcode (LOAD=0 STORE=1 ADD..NOT=2-7 B=8 BZ=9 BN=10 BV=11 BC=12)
- I_FLAG  in  1  IR immediate flag
- ADDR  in  ADDR_W  IR address field
- OF, SF, ZF, CF  in  1 each  ALU flags
- RAM_RDY  in  1  RAM access complete this cycle
- PHASE  out  3  IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 UPDATE=4 HALTED=5
- IR_EN, A_EN, B_EN, PDR_EN, PC_EN, PC_LOAD, ALU_EN, ALU_OE, RAM_OE, RDR_EN  out  1 each  active-high strobes
- PORT_EN, PORT_RD  out  NUM_PORTS each  per-port write / input-read strobes
- RAM_CS  out  1  active-low RAM select
- BUS_ERR  out  1  sticky RAM-timeout flag

## Operation
- State register is reset to IDLE. Strobes are decoded from the state and the IR inputs.
- Reset: PHASE=0, BUS_ERR=0, all strobes 0 and RAM_CS=1. This also applies to assertion mid-instruction, with immediate effect.
- IDLE: all strobes inactive. Goes to FETCH when RUN=1.
- FETCH: RAM_CS=0, RAM_OE=1, IR_EN=1. Holds until RAM_RDY=1, then DECODE.
- DECODE: one cycle, all strobes inactive (IR settle). Then EXECUTE.
- EXECUTE, LOAD with I_FLAG=1: assert the one enable matching ADDR (A_EN, B_EN, PDR_EN or PORT_EN[k]). No RAM access. One cycle.
- EXECUTE, LOAD with I_FLAG=0: RAM_CS=0, RAM_OE=1, RDR_EN=1, plus the matching enable. Held until RAM_RDY=1.
- EXECUTE, STORE to port address (ADDR == IO_BASE+3+k, k < NUM_PORTS): PORT_RD[k]=1, RAM_CS=0.
- EXECUTE, STORE to any other address: ALU_OE=1, RAM_CS=0.
- STORE waits for RAM_RDY in both cases.
- EXECUTE, ADD..NOT: ALU_EN=1, ALU_OE=1, one cycle.
- EXECUTE, branches and undefined opcodes: all strobes inactive, one cycle.
- LOAD addresses outside the I/O map assert no register enable.
- UPDATE: PC_EN=1. PC_LOAD=1 when:
  - OPCODE=B, or
  - BZ&ZF, BN&SF, BV&OF or BC&CF, with flags sampled in this cycle.
- After UPDATE: FETCH if RUN=1, else IDLE.
- Wait counter (8-bit): cleared on entry to any RAM-access state, increments each cycle RAM_RDY=0.
- Timeout: when the count reaches TIMEOUT with RAM_RDY still 0, set BUS_ERR and go to IDLE. The PC is not updated.
- BUS_ERR clears only on reset. RUN leaves IDLE again regardless of BUS_ERR.

## Timing
- Zero-wait instruction: 4 cycles (FETCH, DECODE, EXECUTE, UPDATE). Each RAM wait cycle adds 1.
- Strobes are valid from the cycle the state is entered and drop the cycle after RAM_RDY is sampled high.
- RAM_RDY sampled high on the first access cycle means no wait.
- Timeout path: BUS_ERR=1 and PHASE=IDLE appear TIMEOUT+1 cycles after the access state is entered.
- RUN deasserted mid-instruction: the instruction completes, then the block goes to IDLE.
- Only one enable among A/B/PDR/PORT is ever active. PORT_EN and PORT_RD are never both active.

## Configuration
- SEQ_CTRL_HALT_EN defined: opcode 4'b1111 is HALT.
  - EXECUTE of HALT goes to HALTED without passing through UPDATE, so the PC is not incremented.
  - HALTED: all strobes inactive, PHASE=5.
  - Exit to FETCH on a RUN rising edge (0 then 1, registered).
- Undefined: opcode 15 is an undefined no-op (UPDATE increments the PC), and HALTED is unreachable.

## Test plan
- Reset then RUN=1, OPCODE=2, RAM_RDY=1 -> PHASE 1,2,3,4,1. ALU_EN=ALU_OE=1 only in EXECUTE. PC_EN=1, PC_LOAD=0 in UPDATE.
- LOAD I_FLAG=0 ADDR=65, RAM_RDY low for 3 cycles in EXECUTE -> RAM_CS=0, RDR_EN=1, B_EN=1 for 4 cycles, then UPDATE.
- NUM_PORTS=4: STORE ADDR=69 -> PORT_RD=4'b0100, RAM_CS=0. STORE ADDR=10 -> ALU_OE=1, PORT_RD=0.
- BZ with ZF=1 -> PC_LOAD=1. BZ with ZF=0 -> PC_LOAD=0. BC with CF=1 -> PC_LOAD=1.
- TIMEOUT=15, RAM_RDY held 0 in FETCH -> BUS_ERR=1 and PHASE=0 after 16 cycles. Stays 1 until RESET_N is low.
- RESET_N low during EXECUTE of a LOAD -> outputs reach reset values with no clock edge. With SEQ_CTRL_HALT_EN defined, OPCODE=15 -> PHASE=5 until RUN is toggled 0 then 1.
